// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int FRAME_W_DEF = DATA_W_DEF + 2;

  // Command codes carried in frame bits [9:8]; decoded by the RAM, not here.
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

endpackage

// File: rtl/spi_slave_fsm_if.sv
// Bundle of SPI pins and the RAM-side din/dout handshake.
interface spi_slave_fsm_if #(
  parameter int DATA_W  = 8,
  parameter int FRAME_W = DATA_W + 2
);

  logic               SS_n;
  logic               MOSI;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_slave_fsm_tx_serializer.sv
// Shifts a read byte out MSB-first on a registered MISO line.
module spi_tx_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_abort,
  output logic              o_miso,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(DATA_W);

  logic              r_miso;
  logic              r_busy;
  logic [DATA_W-2:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;

  // The MSB goes out on the load edge itself, so only DATA_W-1 bits remain
  // to shift afterwards; once they are gone the line returns to 0.
  always_ff @(posedge clk) begin
    if (rst || i_abort) begin
      r_miso  <= 1'b0;
      r_busy  <= 1'b0;
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_miso  <= i_data[DATA_W-1];
      r_busy  <= 1'b1;
      r_shift <= i_data[DATA_W-2:0];
      r_cnt   <= CNT_W'(DATA_W - 1);
    end else if (r_cnt != '0) begin
      r_miso  <= r_shift[DATA_W-2];
      r_shift <= {r_shift[DATA_W-3:0], 1'b0};
      r_cnt   <= r_cnt - 1'b1;
    end else begin
      r_miso  <= 1'b0;
      r_busy  <= 1'b0;
    end
  end

  assign o_miso = r_miso;
  assign o_busy = r_busy;

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave framing FSM: deserialises MOSI frames for the RAM and returns
// read bytes on MISO through the serializer.
module spi_slave_fsm
  import spi_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int FRAME_W = DATA_W + 2
) (
  input  logic          CLK,
  input  logic          rst,
  spi_slave_fsm_if.slave bus
);

  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

  state_e             r_state;
  logic [CNT_W-1:0]   r_bitCnt;
  logic [FRAME_W-2:0] r_shift;
  logic [FRAME_W-1:0] r_rxData;
  logic               r_rxValid;
  logic               r_rdAddrSeen;
  logic               r_txTaken;

  logic [FRAME_W-1:0] w_shiftNext;
  logic               w_txLoad;
  logic               w_miso;
  logic               w_serBusy;

  assign w_shiftNext = {r_shift, bus.MOSI};

  // Accept exactly one read byte per READ_DATA frame, and only once the
  // frame has been handed to the RAM; anything else on tx_valid is ignored.
  assign w_txLoad = (r_state == READ_DATA) && (r_bitCnt == CNT_FULL) &&
                    !r_txTaken && !w_serBusy && bus.tx_valid && !bus.SS_n;

  // Main FSM: frame capture, rx strobe and read-address bookkeeping.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state      <= IDLE;
      r_bitCnt     <= '0;
      r_shift      <= '0;
      r_rxData     <= '0;
      r_rxValid    <= 1'b0;
      r_rdAddrSeen <= 1'b0;
      r_txTaken    <= 1'b0;
    end else begin
      r_rxValid <= 1'b0;
      if ((r_state != IDLE) && bus.SS_n) begin
        r_state   <= IDLE;
        r_bitCnt  <= '0;
        r_shift   <= '0;
        r_txTaken <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_bitCnt  <= '0;
            r_shift   <= '0;
            r_txTaken <= 1'b0;
            if (!bus.SS_n) r_state <= CHK_CMD;
          end
          CHK_CMD: begin
            if (!bus.MOSI)        r_state <= WRITE;
            else if (r_rdAddrSeen) r_state <= READ_DATA;
            else                  r_state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (r_bitCnt != CNT_FULL) begin
              r_shift  <= w_shiftNext[FRAME_W-2:0];
              r_bitCnt <= r_bitCnt + 1'b1;
              if (r_bitCnt == CNT_LAST) begin
                r_rxData  <= w_shiftNext;
                r_rxValid <= 1'b1;
                if (r_state == READ_ADD)       r_rdAddrSeen <= 1'b1;
                else if (r_state == READ_DATA) r_rdAddrSeen <= 1'b0;
              end
            end
            if (w_txLoad) r_txTaken <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  spi_tx_serializer #(
    .DATA_W (DATA_W)
  ) u_txSer (
    .clk     (CLK),
    .rst     (rst),
    .i_load  (w_txLoad),
    .i_data  (bus.tx_data),
    .i_abort (bus.SS_n),
    .o_miso  (w_miso),
    .o_busy  (w_serBusy)
  );

  assign bus.MISO     = w_miso;
  assign bus.rx_data  = r_rxData;
  assign bus.rx_valid = r_rxValid;

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Self-checking bench for spi_slave_fsm: a transaction-level model predicts
// rx strobes and MISO bits per cycle; a compare process checks every cycle.
module tb_spi_slave_fsm;

  logic CLK;
  logic rst;
  int   cycle;
  int   vectors;
  int   misses;
  bit   checkEn;
  bit   mRdAddrSeen;

  logic [9:0] rxEvent[int];
  bit         misoExp[int];
  bit         resetAt[int];
  logic [9:0] expRxData;
  logic [7:0] cap;

  spi_slave_fsm_if #(.DATA_W(8)) bus ();

  spi_slave_fsm #(.DATA_W(8), .FRAME_W(10)) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock and cycle index used to timestamp model events.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Per-cycle comparison of all outputs against the model's event tables.
  always @(negedge CLK) begin
    if (checkEn) begin
      bit expValid;
      bit expMiso;
      if (resetAt.exists(cycle)) expRxData = 10'h000;
      expValid = rxEvent.exists(cycle);
      if (expValid) expRxData = rxEvent[cycle];
      expMiso = misoExp.exists(cycle) ? misoExp[cycle] : 1'b0;
      checkOutput("rx_valid", 32'(bus.rx_valid), 32'(expValid));
      checkOutput("rx_data", 32'(bus.rx_data), 32'(expRxData));
      checkOutput("MISO", 32'(bus.MISO), 32'(expMiso));
    end
  end

  // One SPI transaction: select, marker, ten frame bits, optional tx byte,
  // then capture eight MISO bits. abortBit<10 deselects after that many bits;
  // serBits<8 deselects while MISO bit serBits is on the line.
  task automatic applyStimulus(input bit marker, input logic [9:0] frame,
                               input int abortBit, input bit driveTx,
                               input logic [7:0] txByte, input int serBits,
                               output logic [7:0] captured);
    int c;
    bit readData;
    captured = 8'h00;
    bus.SS_n = 1'b0;
    bus.MOSI = 1'b0;
    tick();
    c = cycle;
    bus.MOSI = marker;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == abortBit) begin
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        tick();
        tick();
        return;
      end
      bus.MOSI = frame[9-i];
      tick();
    end
    readData = marker && mRdAddrSeen;
    rxEvent[c+11] = frame;
    if (marker) mRdAddrSeen = !mRdAddrSeen;
    bus.MOSI = 1'b0;
    tick();
    if (driveTx) begin
      bus.tx_valid = 1'b1;
      bus.tx_data  = txByte;
      if (readData)
        for (int j = 0; j < 8 && j <= serBits; j++) misoExp[c+13+j] = txByte[7-j];
    end
    tick();
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    for (int j = 0; j < 8; j++) begin
      captured[7-j] = bus.MISO;
      if (j == serBits) bus.SS_n = 1'b1;
      tick();
    end
    bus.SS_n = 1'b1;
    tick();
    tick();
  endtask

  // Reset asserted after five data bits of a read-address frame.
  task automatic applyResetMidFrame();
    bus.SS_n = 1'b0;
    bus.MOSI = 1'b0;
    tick();
    bus.MOSI = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.MOSI = 1'b1;
      tick();
    end
    rst = 1'b1;
    resetAt[cycle+1] = 1'b1;
    mRdAddrSeen = 1'b0;
    tick();
    rst = 1'b0;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    checkOutput("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
    checkOutput("rst_rx_data", 32'(bus.rx_data), 32'h0);
    checkOutput("rst_MISO", 32'(bus.MISO), 32'h0);
    repeat (12) tick();
  endtask

  initial begin
    vectors = 0;
    misses = 0;
    checkEn = 1'b0;
    mRdAddrSeen = 1'b0;
    expRxData = 10'h000;
    rst = 1'b1;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_rx_valid", 32'(bus.rx_valid), 32'h0);
    checkOutput("reset_rx_data", 32'(bus.rx_data), 32'h0);
    checkOutput("reset_MISO", 32'(bus.MISO), 32'h0);
    checkEn = 1'b1;
    tick();

    applyStimulus(1'b0, 10'h002, 99, 1'b0, 8'h00, 8, cap);
    checkOutput("wr_addr_data", 32'(bus.rx_data), 32'h002);

    applyStimulus(1'b0, 10'h1F0, 99, 1'b1, 8'hFF, 8, cap);
    checkOutput("wr_data_data", 32'(bus.rx_data), 32'h1F0);
    checkOutput("spurious_tx_miso", 32'(cap), 32'h00);

    applyStimulus(1'b1, 10'h202, 99, 1'b0, 8'h00, 8, cap);
    checkOutput("rd_addr_data", 32'(bus.rx_data), 32'h202);

    applyStimulus(1'b1, 10'h3A5, 99, 1'b1, 8'h33, 8, cap);
    checkOutput("rd_data_data", 32'(bus.rx_data), 32'h3A5);
    checkOutput("rd_data_miso", 32'(cap), 32'h33);

    applyStimulus(1'b1, 10'h2FF, 6, 1'b0, 8'h00, 8, cap);
    checkOutput("abort_hold_data", 32'(bus.rx_data), 32'h3A5);

    applyStimulus(1'b1, 10'h255, 99, 1'b1, 8'hAA, 8, cap);
    checkOutput("after_abort_rd_addr_miso", 32'(cap), 32'h00);

    applyStimulus(1'b1, 10'h3C0, 99, 1'b1, 8'hC5, 8, cap);
    checkOutput("rd_data2_miso", 32'(cap), 32'hC5);

    applyStimulus(1'b1, 10'h244, 99, 1'b0, 8'h00, 8, cap);
    applyResetMidFrame();

    applyStimulus(1'b1, 10'h2AB, 99, 1'b1, 8'h5A, 8, cap);
    checkOutput("after_reset_rd_addr_miso", 32'(cap), 32'h00);

    applyStimulus(1'b1, 10'h311, 99, 1'b1, 8'h9B, 3, cap);
    checkOutput("ser_abort_miso", 32'(cap), 32'h90);

    repeat (4) tick();
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/spi_slave_fsm.md
Name: spi_slave_fsm

Overview:
Serial front end of the SPI slave. Deserialises MOSI frames into 10-bit command/data words for the single-port RAM, issuing them on rx_data with a rx_valid pulse. When the RAM returns a read byte on tx_data/tx_valid, the block serialises it MSB-first onto MISO. Sits between the SPI pins and the RAM's din/rx_valid/dout/tx_valid port.

Parameters:
DATA_W, 8, RAM data width; serialised MISO byte width
FRAME_W, 10, rx_data width = DATA_W+2 (2-bit command + 8-bit payload)

Ports:
CLK  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
SS_n  in  1  slave select, active-low; high aborts any transfer
MOSI  in  1  serial data in, sampled on rising CLK while SS_n=0
MISO  out  1  serial data out, registered
rx_data  out  FRAME_W  deserialised frame to RAM din
rx_valid  out  1  one-cycle strobe, rx_data valid
tx_data  in  DATA_W  read byte from RAM dout
tx_valid  in  1  tx_data valid strobe from RAM

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, MISO=0, rx_data=0, rx_valid=0, rd_addr_seen=0, bit counter=0. Reset overrides all other activity, including a frame in progress.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 -> CHK_CMD next cycle. Otherwise stay.
- CHK_CMD: sample the marker bit on MOSI.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_seen=0 -> READ_ADD.
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift in exactly FRAME_W bits, MSB first, one bit per cycle, into an internal shift register.
  - On the cycle after the 10th bit is captured, rx_data is loaded with the full frame and rx_valid=1 for exactly one cycle.
  - rx_data then holds its value until the next frame completes.
  - Frame bits [9:8] are passed through unchanged; the RAM decodes them.
- READ_ADD: on its rx_valid, set rd_addr_seen=1. Remain in state until SS_n=1.
- READ_DATA: on its rx_valid, clear rd_addr_seen=0, then wait for tx_valid.
  - On the cycle tx_valid=1, latch tx_data.
  - Over the next DATA_W cycles, MISO = latched bit 7, 6, ..., 0 (one bit per cycle).
  - Afterwards MISO=0 until SS_n=1.
  - tx_valid arriving outside this wait window is ignored.
- WRITE: remain in state after rx_valid until SS_n=1.
- MISO=0 in every state except the serialisation window.
- SS_n=1 in any non-IDLE state -> IDLE next cycle.
  - Bit counter and shift register are cleared; no rx_valid is issued for a partial frame.
  - rd_addr_seen is preserved unless its setting/clearing rx_valid was already issued.
  - An abort during MISO serialisation stops output; MISO=0.
- Latency: marker bit at cycle c; data bits at c+1..c+10; rx_valid at c+11. With the RAM's one-cycle read, tx_valid arrives at c+12 and MISO carries bit 7 at c+13.
- Back-to-back frames need SS_n high for at least one cycle between them.

Decomposition:
- Package spi_pkg: state_e enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA); command localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11; FRAME_W/DATA_W defaults.
- One natural sub-module: spi_tx_serializer. It loads on tx_valid, shifts DATA_W bits MSB-first to MISO, and exposes a busy flag plus an abort input.

Test Plan:
- Reset mid-frame: assert rst after 5 data bits -> next cycle state=IDLE, MISO=0, rx_valid=0, rx_data=0; no strobe follows.
- Write address: SS_n=0, marker 0, bits 00_0000_0010 -> rx_data=10'h002, rx_valid high exactly one cycle at c+11.
- Write data: marker 0, bits 01_1111_0000 -> rx_data=10'h1F0 with a single rx_valid pulse; MISO stays 0 throughout.
- Read sequence: marker 1, frame 10_0000_0010 -> rx_data=10'h202, rd_addr_seen=1. Next frame: marker 1, bits 11_xxxx_xxxx -> rx_valid; bench drives tx_valid with tx_data=8'h33 one cycle later -> MISO = 0,0,1,1,0,0,1,1 over the following 8 cycles; rd_addr_seen=0.
- Abort: SS_n=1 after 6 bits of a READ_ADD frame -> IDLE, no rx_valid, rd_addr_seen stays 0. Next marker 1 goes to READ_ADD.
- Spurious tx_valid: tx_valid=1 with tx_data=8'hFF while in WRITE -> MISO stays 0.
